// File: rtl/bus_datapath_n.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR, HI/LO/Y/Z, I/O ports,
// a single-cycle ALU and an iterative signed multiply/divide engine.
module bus_datapath_n #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [3:0]          bus_src,
    input  logic [SEL_W-1:0]    reg_sel,
    input  logic                reg_in,
    input  logic                ba_out,
    input  logic                pc_in,
    input  logic                inc_pc,
    input  logic                ir_in,
    input  logic                y_in,
    input  logic                z_in,
    input  logic                hi_in,
    input  logic                lo_in,
    input  logic                mar_in,
    input  logic                mdr_in,
    input  logic                outport_in,
    input  logic                read,
    input  logic [3:0]          alu_op,
    input  logic                alu_start,
    input  logic [DATA_W-1:0]   mdata_in,
    input  logic [DATA_W-1:0]   inport_data,
    input  logic [DATA_W-1:0]   c_imm,
    output logic [DATA_W-1:0]   bus_data,
    output logic [DATA_W-1:0]   mar_out,
    output logic [DATA_W-1:0]   mdr_out,
    output logic [DATA_W-1:0]   ir_out,
    output logic [DATA_W-1:0]   outport_out,
    output logic [2*DATA_W-1:0] z_out,
    output logic                alu_busy,
    output logic                alu_done,
    output logic                bus_err
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd12;

    typedef enum logic [0:0] {S_IDLE, S_BUSY} md_state_t;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_pc, r_ir, r_mar, r_mdr, r_hi, r_lo, r_y;
    logic [DATA_W-1:0]   r_outport, r_inport;
    logic [2*DATA_W-1:0] r_z;

    md_state_t           r_state, w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_opb;
    logic                r_is_div, r_neg_q, r_neg_r, r_div_zero, r_done;

    logic [DATA_W-1:0]   w_bus;
    logic                w_bus_err;
    logic [DATA_W-1:0]   w_alu, w_ror, w_rol, w_abs_a, w_abs_b;
    logic [SH_W-1:0]     w_sh, w_nsh;
    logic                w_start_ok, w_finish;
    logic [DATA_W:0]     w_mul_sum, w_div_rsh;
    logic [DATA_W-1:0]   w_div_rem, w_q_mag, w_r_mag, w_q_fin, w_r_fin;
    logic                w_div_ge;
    logic [2*DATA_W-1:0] w_mul_next, w_div_next, w_step, w_md_res;

    always_comb begin
        w_bus     = '0;
        w_bus_err = 1'b0;
        case (bus_src)
            4'd0:    w_bus = (ba_out && reg_sel == '0) ? '0 : r_regs[reg_sel];
            4'd1:    w_bus = r_hi;
            4'd2:    w_bus = r_lo;
            4'd3:    w_bus = r_z[2*DATA_W-1:DATA_W];
            4'd4:    w_bus = r_z[DATA_W-1:0];
            4'd5:    w_bus = r_pc;
            4'd6:    w_bus = r_mdr;
            4'd7:    w_bus = r_inport;
            4'd8:    w_bus = c_imm;
            default: w_bus_err = 1'b1;
        endcase
    end

    // Rotate-left by s is rotate-right by (W - s) mod W, so one doubled word serves both.
    always_comb begin
        w_sh  = w_bus[SH_W-1:0];
        w_nsh = -w_sh;
        w_ror = DATA_W'({r_y, r_y} >> w_sh);
        w_rol = DATA_W'({r_y, r_y} >> w_nsh);
        w_alu = '0;
        case (alu_op)
            4'd0:    w_alu = r_y + w_bus;
            4'd1:    w_alu = r_y - w_bus;
            4'd2:    w_alu = r_y & w_bus;
            4'd3:    w_alu = r_y | w_bus;
            4'd4:    w_alu = r_y >> w_sh;
            4'd5:    w_alu = $signed(r_y) >>> w_sh;
            4'd6:    w_alu = r_y << w_sh;
            4'd7:    w_alu = w_ror;
            4'd8:    w_alu = w_rol;
            4'd9:    w_alu = -w_bus;
            4'd10:   w_alu = ~w_bus;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_pc      <= '0;
            r_ir      <= '0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_y       <= '0;
            r_outport <= '0;
            r_inport  <= '0;
        end else begin
            if (reg_in) r_regs[reg_sel] <= w_bus;
            if (pc_in)
                r_pc <= w_bus;
            else if (inc_pc)
                r_pc <= r_pc + DATA_W'(1);
            if (mdr_in)     r_mdr     <= read ? mdata_in : w_bus;
            if (ir_in)      r_ir      <= w_bus;
            if (mar_in)     r_mar     <= w_bus;
            if (hi_in)      r_hi      <= w_bus;
            if (lo_in)      r_lo      <= w_bus;
            if (y_in)       r_y       <= w_bus;
            if (outport_in) r_outport <= w_bus;
            r_inport <= inport_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_start_ok   = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (alu_start && (alu_op == OP_MUL || alu_op == OP_DIV)) begin
                    w_start_ok   = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_LAST) begin
                    w_finish     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Both engines work on magnitudes; signs are reapplied on the final step.
    always_comb begin
        w_abs_a    = r_y[DATA_W-1] ? -r_y : r_y;
        w_abs_b    = w_bus[DATA_W-1] ? -w_bus : w_bus;
        w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};
        w_div_rsh  = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
        w_div_ge   = (w_div_rsh >= {1'b0, r_opb});
        w_div_rem  = w_div_ge ? DATA_W'(w_div_rsh - {1'b0, r_opb}) : DATA_W'(w_div_rsh);
        w_div_next = {w_div_rem, r_acc[DATA_W-2:0], w_div_ge};
        w_step     = r_is_div ? w_div_next : w_mul_next;
        w_q_mag    = w_step[DATA_W-1:0];
        w_r_mag    = w_step[2*DATA_W-1:DATA_W];
        // A zero divisor leaves |dividend| as the remainder; only the quotient needs forcing.
        w_q_fin    = r_div_zero ? '1 : (r_neg_q ? -w_q_mag : w_q_mag);
        w_r_fin    = r_neg_r ? -w_r_mag : w_r_mag;
        w_md_res   = r_is_div ? {w_r_fin, w_q_fin} : (r_neg_q ? -w_step : w_step);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_start_ok) begin
                r_cnt      <= '0;
                r_acc      <= {{DATA_W{1'b0}}, w_abs_a};
                r_opb      <= w_abs_b;
                r_is_div   <= (alu_op == OP_DIV);
                r_neg_q    <= r_y[DATA_W-1] ^ w_bus[DATA_W-1];
                r_neg_r    <= r_y[DATA_W-1];
                r_div_zero <= (w_bus == '0);
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= w_step;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            r_z <= '0;
        else if (w_finish)
            r_z <= w_md_res;
        else if (z_in && r_state == S_IDLE && !r_done)
            r_z <= {{DATA_W{1'b0}}, w_alu};
    end

    assign bus_data    = w_bus;
    assign bus_err     = w_bus_err;
    assign mar_out     = r_mar;
    assign mdr_out     = r_mdr;
    assign ir_out      = r_ir;
    assign outport_out = r_outport;
    assign z_out       = r_z;
    assign alu_busy    = (r_state == S_BUSY);
    assign alu_done    = r_done;

endmodule

// File: tb/tb_bus_datapath_n.sv
// Directed testbench for bus_datapath_n: bus mux, register loads, single-cycle
// ALU, multiply/divide handshake and asynchronous reset.
module tb_bus_datapath_n;

    logic        clk, clr;
    logic [3:0]  bus_src;
    logic [3:0]  reg_sel;
    logic        reg_in, ba_out, pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in;
    logic        mar_in, mdr_in, outport_in, read, alu_start;
    logic [3:0]  alu_op;
    logic [31:0] mdata_in, inport_data, c_imm;
    logic [31:0] bus_data, mar_out, mdr_out, ir_out, outport_out;
    logic [63:0] z_out;
    logic        alu_busy, alu_done, bus_err;

    int errors = 0;
    int checks = 0;

    bus_datapath_n #(.DATA_W(32), .NUM_REGS(16)) dut (
        .clk(clk), .clr(clr), .bus_src(bus_src), .reg_sel(reg_sel),
        .reg_in(reg_in), .ba_out(ba_out), .pc_in(pc_in), .inc_pc(inc_pc),
        .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in), .read(read),
        .alu_op(alu_op), .alu_start(alu_start), .mdata_in(mdata_in),
        .inport_data(inport_data), .c_imm(c_imm), .bus_data(bus_data),
        .mar_out(mar_out), .mdr_out(mdr_out), .ir_out(ir_out),
        .outport_out(outport_out), .z_out(z_out), .alu_busy(alu_busy),
        .alu_done(alu_done), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle 1 time unit so outputs are sampled away from the edge.
    task applyStimulus;
        @(posedge clk);
        #1;
    endtask

    task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task clearControls;
        reg_in = 0; ba_out = 0; pc_in = 0; inc_pc = 0; ir_in = 0; y_in = 0;
        z_in = 0; hi_in = 0; lo_in = 0; mar_in = 0; mdr_in = 0; outport_in = 0;
        read = 0; alu_start = 0; alu_op = 4'd0;
    endtask

    task loadY(input logic [31:0] val);
        bus_src = 4'd8; c_imm = val; y_in = 1;
        applyStimulus();
        y_in = 0;
    endtask

    // Called with the sample just after a MUL/DIV start edge; returns the sample index of done.
    task runUntilDone(output int lat, output int busyCnt);
        lat = -1;
        busyCnt = 0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (alu_busy) busyCnt++;
            if (alu_done) lat = i;
            else applyStimulus();
        end
    endtask

    initial begin
        int lat, busyCnt, doneCnt, doneAt;

        clr = 0; bus_src = 4'd5; reg_sel = '0; mdata_in = '0; inport_data = '0; c_imm = '0;
        clearControls();
        applyStimulus();
        applyStimulus();
        checkOutput("reset_z", z_out, 64'h0);
        checkOutput("reset_busy", {63'h0, alu_busy}, 64'h0);
        checkOutput("reset_done", {63'h0, alu_done}, 64'h0);
        checkOutput("reset_pc", {32'h0, bus_data}, 64'h0);
        clr = 1;

        // Register file and bus mux
        bus_src = 4'd8; c_imm = 32'hDEADBEEF; reg_sel = 4'd7; reg_in = 1;
        applyStimulus();
        reg_in = 0; bus_src = 4'd0;
        #1 checkOutput("r7_read", {32'h0, bus_data}, 64'hDEADBEEF);
        checkOutput("bus_err_ok", {63'h0, bus_err}, 64'h0);
        bus_src = 4'd8; c_imm = 32'd5; reg_sel = 4'd0; reg_in = 1;
        applyStimulus();
        reg_in = 0; bus_src = 4'd0; ba_out = 1;
        #1 checkOutput("r0_ba_out", {32'h0, bus_data}, 64'h0);
        ba_out = 0;
        #1 checkOutput("r0_read", {32'h0, bus_data}, 64'h5);
        bus_src = 4'd12;
        #1 checkOutput("bus_illegal", {32'h0, bus_data}, 64'h0);
        checkOutput("bus_err_set", {63'h0, bus_err}, 64'h1);

        // PC wrap and load priority
        bus_src = 4'd8; c_imm = 32'hFFFFFFFF; pc_in = 1;
        applyStimulus();
        pc_in = 0; inc_pc = 1;
        applyStimulus();
        inc_pc = 0; bus_src = 4'd5;
        #1 checkOutput("pc_wrap", {32'h0, bus_data}, 64'h0);
        bus_src = 4'd8; c_imm = 32'h40; pc_in = 1; inc_pc = 1;
        applyStimulus();
        pc_in = 0; inc_pc = 0; bus_src = 4'd5;
        #1 checkOutput("pc_in_wins", {32'h0, bus_data}, 64'h40);

        // MDR sources, inport latency, other loads
        read = 1; mdata_in = 32'h1234; mdr_in = 1;
        applyStimulus();
        checkOutput("mdr_mem", {32'h0, mdr_out}, 64'h1234);
        read = 0; bus_src = 4'd8; c_imm = 32'hCAFE;
        applyStimulus();
        mdr_in = 0;
        checkOutput("mdr_bus", {32'h0, mdr_out}, 64'hCAFE);
        inport_data = 32'hA5A50F0F;
        applyStimulus();
        bus_src = 4'd7;
        #1 checkOutput("inport", {32'h0, bus_data}, 64'hA5A50F0F);
        bus_src = 4'd8; c_imm = 32'h55AA1234; ir_in = 1; mar_in = 1; outport_in = 1;
        applyStimulus();
        ir_in = 0; mar_in = 0; outport_in = 0;
        checkOutput("ir", {32'h0, ir_out}, 64'h55AA1234);
        checkOutput("mar", {32'h0, mar_out}, 64'h55AA1234);
        checkOutput("outport", {32'h0, outport_out}, 64'h55AA1234);
        c_imm = 32'h1111; hi_in = 1;
        applyStimulus();
        hi_in = 0; c_imm = 32'h2222; lo_in = 1;
        applyStimulus();
        lo_in = 0; bus_src = 4'd1;
        #1 checkOutput("hi", {32'h0, bus_data}, 64'h1111);
        bus_src = 4'd2;
        #1 checkOutput("lo", {32'h0, bus_data}, 64'h2222);

        // Single-cycle ALU
        loadY(32'h80000000);
        c_imm = 32'd4; alu_op = 4'd5; z_in = 1;
        applyStimulus();
        z_in = 0;
        checkOutput("shra", z_out, 64'h00000000_F8000000);
        bus_src = 4'd4;
        #1 checkOutput("bus_zlo", {32'h0, bus_data}, 64'hF8000000);
        loadY(32'h80000001);
        c_imm = 32'd1; alu_op = 4'd8; z_in = 1;
        applyStimulus();
        checkOutput("rol", z_out, 64'h3);
        alu_op = 4'd7;
        applyStimulus();
        z_in = 0;
        checkOutput("ror", z_out, 64'hC0000000);
        alu_op = 4'd0; alu_start = 1;
        applyStimulus();
        alu_start = 0;
        checkOutput("start_bad_op", {63'h0, alu_busy}, 64'h0);

        // MUL -7 * 6 with disturbances while busy
        loadY(32'hFFFFFFF9);
        c_imm = 32'd6; alu_op = 4'd11; alu_start = 1;
        applyStimulus();
        alu_start = 0;
        busyCnt = 0; doneCnt = 0; doneAt = -1;
        for (int i = 0; i < 40; i++) begin
            if (alu_busy) busyCnt++;
            if (alu_done) begin
                doneCnt++;
                doneAt = i;
            end
            if (i >= 5 && i <= 8) begin
                alu_start = 1; alu_op = 4'd12; z_in = 1; y_in = 1; c_imm = 32'h1234;
            end else begin
                clearControls();
            end
            applyStimulus();
        end
        checkOutput("mul_busy_cycles", busyCnt, 32);
        checkOutput("mul_done_count", doneCnt, 1);
        checkOutput("mul_done_at", doneAt, 32);
        checkOutput("mul_result", z_out, 64'hFFFFFFFF_FFFFFFD6);

        // DIV -17 / 5; Y reloaded mid-operation for the next divide
        loadY(32'hFFFFFFEF);
        c_imm = 32'd5; alu_op = 4'd12; alu_start = 1;
        applyStimulus();
        alu_start = 0; y_in = 1; c_imm = 32'd9;
        applyStimulus();
        y_in = 0;
        // Sampling starts one edge after launch, so done is expected one index earlier.
        runUntilDone(lat, busyCnt);
        checkOutput("div1_latency", lat, 31);
        checkOutput("div1_busy", busyCnt, 31);
        checkOutput("div1_result", z_out, 64'hFFFFFFFE_FFFFFFFD);

        // Back-to-back 9 / 0 started in the done cycle, with a competing z_in
        bus_src = 4'd8; c_imm = 32'd0; alu_op = 4'd12; alu_start = 1; z_in = 1;
        applyStimulus();
        alu_start = 0; z_in = 0;
        checkOutput("b2b_busy", {63'h0, alu_busy}, 64'h1);
        checkOutput("done_z_in_ignored", z_out, 64'hFFFFFFFE_FFFFFFFD);
        runUntilDone(lat, busyCnt);
        checkOutput("div0_latency", lat, 32);
        checkOutput("div0_result", z_out, 64'h00000009_FFFFFFFF);

        // SUB clears the high half of Z
        loadY(32'd3);
        c_imm = 32'd5; alu_op = 4'd1; z_in = 1;
        applyStimulus();
        z_in = 0;
        checkOutput("sub", z_out, 64'h00000000_FFFFFFFE);

        // Reset in cycle 5 of a MUL
        loadY(32'd3);
        c_imm = 32'd3; alu_op = 4'd11; alu_start = 1;
        applyStimulus();
        alu_start = 0;
        for (int i = 0; i < 4; i++) applyStimulus();
        clr = 0; bus_src = 4'd1;
        #1 checkOutput("rst_busy", {63'h0, alu_busy}, 64'h0);
        checkOutput("rst_z", z_out, 64'h0);
        checkOutput("rst_hi_bus", {32'h0, bus_data}, 64'h0);
        applyStimulus();
        clr = 1;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (alu_done) doneCnt++;
            applyStimulus();
        end
        checkOutput("rst_no_done", doneCnt, 0);
        checkOutput("rst_z_after", z_out, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_datapath_n.md
Name: bus_datapath_n

Overview:
- Parametrised single-bus CPU datapath: register file, PC, IR, MAR, MDR, HI/LO, Y, 64-bit-style Z, in/out ports and ALU around one shared bus.
- Generalises width and register count, and replaces per-register one-hot controls with encoded selects.
- Adds a multi-cycle signed multiply/divide engine with a start/busy/done handshake.
- Driven cycle-by-cycle by the control unit; connects to the memory model through MAR/MDR.

Parameters:
- DATA_W, 32, datapath word width; must be a power of 2, at least 8.
- NUM_REGS, 16, number of general registers; must be a power of 2.
- SEL_W, $clog2(NUM_REGS), register select width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-low reset
- bus_src  in  4  bus source code
- reg_sel  in  SEL_W  register index for read and write
- reg_in  in  1  write bus into reg[reg_sel]
- ba_out  in  1  force a register-file read of R0 to 0
- pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in  in  1 each  load enables
- read  in  1  MDR source select: 1 = mdata_in, 0 = bus
- alu_op  in  4  ALU operation
- alu_start  in  1  launch MUL/DIV
- mdata_in  in  DATA_W  memory read data
- inport_data  in  DATA_W  external input port
- c_imm  in  DATA_W  sign-extended immediate from control
- bus_data  out  DATA_W  current bus value
- mar_out, mdr_out, ir_out, outport_out  out  DATA_W  register contents
- z_out  out  2*DATA_W  Z register
- alu_busy  out  1  MUL/DIV in progress
- alu_done  out  1  one-cycle completion pulse
- bus_err  out  1  illegal bus_src

Behaviour:
- Reset (clr=0, asynchronous):
  - All registers, Z, inport register and MUL/DIV state cleared to 0.
  - alu_busy=0, alu_done=0.
  - A reset mid-operation aborts it; no Z write occurs.
- Bus (combinational) by bus_src:
  - 0: reg[reg_sel], forced to 0 when reg_sel==0 and ba_out=1.
  - 1: HI; 2: LO; 3: Z[2W-1:W]; 4: Z[W-1:0]; 5: PC; 6: MDR; 7: inport register; 8: c_imm.
  - 9-15: bus=0 and bus_err=1; otherwise bus_err=0.
- Register loads (rising edge, from bus):
  - reg_in writes reg[reg_sel]; R0 is physically writable.
  - pc_in loads PC; inc_pc increments PC by 1 with wrap-around; pc_in wins if both are asserted.
  - mdr_in loads MDR from mdata_in if read=1, else from bus.
  - IR, MAR, HI, LO, Y and the outport register load on their enables.
  - The inport register samples inport_data every cycle (1-cycle latency).
- ALU operands: A=Y, B=bus. Shift/rotate amount is B[$clog2(DATA_W)-1:0].
- Single-cycle ops (Z loaded on the edge when z_in=1):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG(B), 10 NOT(B).
  - Result goes to Z[W-1:0]; Z[2W-1:W] is cleared; carry is discarded.
  - Codes 13-15 write Z=0.
- Multi-cycle ops: 11 MUL, 12 DIV.
  - alu_start=1 with op 11/12 latches A, B and op at edge k.
  - alu_busy is 1 after edge k through edge k+DATA_W.
  - At edge k+DATA_W: Z is written, alu_busy falls, and alu_done=1 for exactly one cycle.
  - MUL: Z = signed 2W product (shift-add).
  - DIV: signed restoring divide, truncating toward zero; Z = {remainder, quotient}; remainder takes the dividend's sign.
  - Divide by zero: quotient all ones, remainder = dividend, same latency.
- Handshake rules:
  - alu_start while busy is ignored.
  - alu_start with an op other than 11/12 is ignored.
  - z_in while busy is ignored.
  - z_in in the done cycle is ignored; the MUL/DIV result has priority.
  - Y and bus may change freely during busy, because the operands are latched.
  - alu_start may be reasserted in the cycle alu_done is high; busy then resumes on the next edge.

Test Plan:
- Reset: drive clr low mid-MUL (cycle 5 of 32) -> alu_busy=0, z_out=0, bus_data=0 with bus_src=1; no alu_done pulse afterwards.
- Register/bus: write 0xDEADBEEF to R7, then bus_src=0, reg_sel=7 -> bus 0xDEADBEEF. R0=5 with ba_out=1 -> bus 0. bus_src=12 -> bus 0, bus_err=1.
- PC/MDR: PC=0xFFFFFFFF, inc_pc -> 0. pc_in+inc_pc with bus=0x40 -> 0x40. read=1, mdr_in, mdata_in=0x1234 -> mdr_out=0x1234.
- Single-cycle ALU: Y=0x80000000, B=4, SHRA -> Z=0x00000000_F8000000. ROL of 0x80000001 by 1 -> 0x00000003. SUB 3-5 -> Z low 0xFFFFFFFE, Z high 0.
- MUL: Y=-7, B=6, start -> busy for 32 cycles, done pulse exactly once, Z=0xFFFFFFFF_FFFFFFD6. Start pulses and z_in during busy have no effect.
- DIV: -17/5 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFE. 9/0 -> quotient 0xFFFFFFFF, remainder 9, same 32-cycle latency. Back-to-back start in the done cycle is accepted.
